ram_sync_mc: RTL and testbench
==============================

Name: ram_sync_mc

Overview:
- Clocked, parametrised successor to the ram256x8 asynchronous memory.
- Byte-addressed, big-endian storage with the MOV/MOC handshake and the DataType selection of byte, halfword, word or doubleword.
- Adds a programmable wait-state count, sign-extended loads, alignment checking with an Error flag, and true two-beat doubleword transfers.
- Sits between the ARM datapath's MAR/MDR and the instruction/data store; preloaded by the bench through the Mem array.

Parameters:
- ADDR_WIDTH, 8: byte address width. DEPTH = 2**ADDR_WIDTH bytes.
- DATA_WIDTH, 32: beat width. Fixed at 32 in this generation; checked by an elaboration assertion.
- WAIT_CYCLES, 2: idle cycles between accepting MOV and asserting MOC. Legal range 0..15.

Ports:
- Clk, input, 1: the single clock. Rising edge.
- Reset, input, 1: synchronous, active-high.
- MOV, input, 1: memory operation valid. Held high by the master until the transfer ends.
- ReadWrite, input, 1: 1 = read, 0 = write.
- DataType, input, 2: 00 byte, 01 halfword, 10 word, 11 doubleword.
- SignedLoad, input, 1: 1 = sign-extend byte/halfword reads; 0 = zero-extend.
- Address, input, ADDR_WIDTH: byte address.
- DataIn, input, 32: write data, right-justified for byte and halfword.
- DataOut, output, 32: read data.
- MOC, output, 1: memory operation complete. One-cycle pulse per beat.
- Error, output, 1: misaligned request flag.

Behaviour:
- Reset (synchronous): state goes to IDLE; MOC=0, Error=0, DataOut=0, wait counter=0. Mem contents are preserved. A reset mid-transfer aborts it. A doubleword write that has already committed beat 1 keeps beat 1; beat 2 is not written.
- FSM states:
  - IDLE: on MOV=1, latch Address, ReadWrite, DataType and SignedLoad; load counter=WAIT_CYCLES; go to WAIT.
  - WAIT: decrement the counter; at 0, perform the beat and go to ACK.
  - ACK: MOC=1 for exactly this cycle. If DataType=11, beat=1 and MOV=1: beat=2, address += 4 (mod DEPTH), reload counter, go to WAIT. Otherwise go to HOLD.
  - HOLD: wait for MOV=0, then return to IDLE. A new request needs a MOV low-to-high cycle.
- Latency: MOV sampled at edge k means MOC is high during the cycle after edge k+WAIT_CYCLES+1. For a doubleword, the second MOC follows the first by WAIT_CYCLES+2 cycles.
- Write, big-endian (A = latched address):
  - Byte: Mem[A] = DataIn[7:0].
  - Halfword: Mem[A] = DataIn[15:8], Mem[A+1] = DataIn[7:0].
  - Word and each doubleword beat: Mem[A..A+3] = DataIn[31:24] .. DataIn[7:0].
  - DataIn is sampled at the edge that performs the beat. For beat 2 the master must have changed DataIn by then.
- Read:
  - DataOut is registered at the beat edge and is valid while MOC=1.
  - It holds its value until the next read beat; writes do not change DataOut.
  - Byte and halfword reads are extended according to SignedLoad.
- Alignment:
  - Halfword requires A[0]=0; word and doubleword require A[1:0]=00.
  - A misaligned request goes through the normal timing but performs no Mem write and leaves DataOut unchanged.
  - Error=1 is asserted coincident with MOC. A misaligned doubleword has no second beat.
- MOV dropped before ACK: the current beat still completes and pulses MOC. A pending doubleword beat 2 is cancelled with no Error.
- Wrap-around: beat-2 address and byte offsets are computed modulo DEPTH.
- Changes to inputs after latching are ignored, except DataIn, which is sampled per beat.

Decomposition:
- Package ram_pkg:
  - DataType encodings DT_BYTE, DT_HALF, DT_WORD, DT_DWORD.
  - FSM state enum IDLE, WAIT, ACK, HOLD.
  - A function computing the alignment check.
- Sub-module ram_byte_array:
  - Holds reg [7:0] Mem [0:DEPTH-1], hierarchical name kept as Mem for bench preload.
  - Provides a 4-lane byte write enable and a 4-byte big-endian read port.

Test Plan:
- Preload Mem[0..3] = FF,D3,81,97; word read at 0x00, WAIT_CYCLES=2 -> MOC exactly 4 cycles after the MOV sample edge; DataOut=0xFFD38197; Error=0.
- Byte write DataIn=0xFFD38197 at 0x0C, then SignedLoad byte read -> Mem[0x0C]=0x97; DataOut=0xFFFFFF97. Same read with SignedLoad=0 -> 0x00000097.
- Halfword write 0x8197 at 0x10, then signed read -> Mem[0x10]=0x81, Mem[0x11]=0x97; DataOut=0xFFFF8197.
- Doubleword write 0x00000001 then 0x00000003 at 0xFC -> two MOC pulses; Mem[0xFC..0xFF]=00,00,00,01 and Mem[0x00..0x03]=00,00,00,03 (wrap). Readback returns the same two words.
- Word write at 0x06 -> MOC with Error=1; Mem[0x04..0x09] unchanged; DataOut unchanged.
- Reset asserted during WAIT of doubleword beat 2 -> next cycle MOC=0, DataOut=0; beat-1 bytes written; beat-2 bytes unchanged.

Source files
------------

// File: rtl/ram_pkg.sv
// Shared encodings and helpers for the ram_sync_mc clocked byte-addressed memory.
package ram_pkg;

    typedef enum logic [1:0] {
        DT_BYTE  = 2'b00,
        DT_HALF  = 2'b01,
        DT_WORD  = 2'b10,
        DT_DWORD = 2'b11
    } data_type_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        ACK  = 2'b10,
        HOLD = 2'b11
    } state_e;

    localparam int unsigned BEAT_BYTES = 4;

    // Halfwords need an even address; words and doublewords need a 4-byte boundary.
    function automatic logic is_aligned(input data_type_e dt, input logic [1:0] lsb);
        logic ok;
        case (dt)
            DT_BYTE:           ok = 1'b1;
            DT_HALF:           ok = (lsb[0] == 1'b0);
            DT_WORD, DT_DWORD: ok = (lsb == 2'b00);
            default:           ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/ram_byte_array.sv
// Byte storage with four big-endian lanes: lane i is address addr+i (mod DEPTH),
// carried on data bits [31-8*i -: 8].
module ram_byte_array #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic [3:0]            we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [7:0]            Mem [0:DEPTH-1];
    logic [ADDR_WIDTH-1:0] lane_addr_s [4];

    // Lane addresses wrap naturally at the top of the array.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            lane_addr_s[i] = addr + ADDR_WIDTH'(i);
        end
    end

    // Per-lane byte writes.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we[i]) begin
                Mem[lane_addr_s[i]] <= wdata[31-8*i -: 8];
            end
        end
    end

    // Four-byte read window starting at addr.
    always_comb begin
        rdata = {Mem[lane_addr_s[0]], Mem[lane_addr_s[1]],
                 Mem[lane_addr_s[2]], Mem[lane_addr_s[3]]};
    end

endmodule

// File: rtl/ram_sync_mc_chk.sv
// Elaboration-time parameter checks for ram_sync_mc.
module ram_sync_mc_chk #(
    parameter int DATA_WIDTH  = 32,
    parameter int WAIT_CYCLES = 2
) ();

    if (DATA_WIDTH != 32) begin : g_bad_width
        $error("ram_sync_mc: DATA_WIDTH must be 32");
    end

    if ((WAIT_CYCLES < 0) || (WAIT_CYCLES > 15)) begin : g_bad_wait
        $error("ram_sync_mc: WAIT_CYCLES must be within 0..15");
    end

endmodule

// File: rtl/ram_sync_mc.sv
// Clocked big-endian memory with MOV/MOC handshake, programmable wait states,
// sign-extending loads, alignment error flag and two-beat doubleword transfers.
module ram_sync_mc
    import ram_pkg::*;
#(
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 32,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  MOV,
    input  logic                  ReadWrite,
    input  logic [1:0]            DataType,
    input  logic                  SignedLoad,
    input  logic [ADDR_WIDTH-1:0] Address,
    input  logic [31:0]           DataIn,
    output logic [31:0]           DataOut,
    output logic                  MOC,
    output logic                  Error
);

    localparam logic [3:0]            WAIT_LOAD = 4'(WAIT_CYCLES);
    localparam logic [ADDR_WIDTH-1:0] BEAT_STEP = ADDR_WIDTH'(BEAT_BYTES);

    state_e                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  rw_q, rw_d;
    data_type_e            dt_q, dt_d;
    logic                  sgn_q, sgn_d;
    logic                  beat2_q, beat2_d;
    logic                  moc_q, moc_d;
    logic                  err_q, err_d;
    logic [31:0]           dout_q, dout_d;

    logic [3:0]            we_s;
    logic [31:0]           wdata_s;
    logic [31:0]           rdata_s;
    logic                  beat_s;
    logic                  aligned_s;

    ram_sync_mc_chk #(
        .DATA_WIDTH  (DATA_WIDTH),
        .WAIT_CYCLES (WAIT_CYCLES)
    ) u_chk ();

    ram_byte_array #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_array (
        .clk   (Clk),
        .we    (we_s),
        .addr  (addr_q),
        .wdata (wdata_s),
        .rdata (rdata_s)
    );

    // Handshake sequencing, beat execution and read-data formatting.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        rw_d      = rw_q;
        dt_d      = dt_q;
        sgn_d     = sgn_q;
        beat2_d   = beat2_q;
        moc_d     = 1'b0;
        err_d     = 1'b0;
        dout_d    = dout_q;
        we_s      = 4'b0000;
        wdata_s   = DataIn;
        beat_s    = 1'b0;
        aligned_s = is_aligned(dt_q, addr_q[1:0]);

        case (state_q)
            IDLE: begin
                if (MOV) begin
                    addr_d  = Address;
                    rw_d    = ReadWrite;
                    dt_d    = data_type_e'(DataType);
                    sgn_d   = SignedLoad;
                    beat2_d = 1'b0;
                    cnt_d   = WAIT_LOAD;
                    state_d = WAIT;
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    beat_s  = 1'b1;
                    moc_d   = 1'b1;
                    err_d   = ~aligned_s;
                    state_d = ACK;
                end else begin
                    cnt_d   = cnt_q - 4'd1;
                    state_d = WAIT;
                end
            end
            ACK: begin
                // A second doubleword beat only follows an aligned first beat
                // while the master still holds MOV.
                if ((dt_q == DT_DWORD) && !beat2_q && MOV && aligned_s) begin
                    beat2_d = 1'b1;
                    addr_d  = addr_q + BEAT_STEP;
                    cnt_d   = WAIT_LOAD;
                    state_d = WAIT;
                end else begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (!MOV) begin
                    state_d = IDLE;
                end else begin
                    state_d = HOLD;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Reset on the beat edge aborts the beat, including its Mem write.
        if (beat_s && aligned_s && !Reset) begin
            if (!rw_q) begin
                case (dt_q)
                    DT_BYTE: begin
                        we_s    = 4'b0001;
                        wdata_s = {DataIn[7:0], 24'h000000};
                    end
                    DT_HALF: begin
                        we_s    = 4'b0011;
                        wdata_s = {DataIn[15:0], 16'h0000};
                    end
                    default: begin
                        we_s    = 4'b1111;
                        wdata_s = DataIn;
                    end
                endcase
            end else begin
                case (dt_q)
                    DT_BYTE: begin
                        dout_d = sgn_q ? {{24{rdata_s[31]}}, rdata_s[31:24]}
                                       : {24'h000000, rdata_s[31:24]};
                    end
                    DT_HALF: begin
                        dout_d = sgn_q ? {{16{rdata_s[31]}}, rdata_s[31:16]}
                                       : {16'h0000, rdata_s[31:16]};
                    end
                    default: begin
                        dout_d = rdata_s;
                    end
                endcase
            end
        end else begin
            we_s = 4'b0000;
        end
    end

    // State and output registers with synchronous reset; Mem is not reset.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            rw_q    <= 1'b0;
            dt_q    <= DT_BYTE;
            sgn_q   <= 1'b0;
            beat2_q <= 1'b0;
            moc_q   <= 1'b0;
            err_q   <= 1'b0;
            dout_q  <= 32'h00000000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            rw_q    <= rw_d;
            dt_q    <= dt_d;
            sgn_q   <= sgn_d;
            beat2_q <= beat2_d;
            moc_q   <= moc_d;
            err_q   <= err_d;
            dout_q  <= dout_d;
        end
    end

    assign DataOut = dout_q;
    assign MOC     = moc_q;
    assign Error   = err_q;

endmodule

// File: tb/tb_ram_sync_mc.sv
// Self-checking bench for ram_sync_mc against a byte-array reference model.
module tb_ram_sync_mc;

    localparam int WC = 2;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        MOV = 1'b0;
    logic        ReadWrite = 1'b0;
    logic [1:0]  DataType = 2'b00;
    logic        SignedLoad = 1'b0;
    logic [7:0]  Address = 8'h00;
    logic [31:0] DataIn = 32'h0;
    logic [31:0] DataOut;
    logic        MOC;
    logic        Error;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [7:0]  mdl [0:255];
    logic [31:0] mdl_dout = 32'h0;

    ram_sync_mc #(
        .ADDR_WIDTH  (8),
        .DATA_WIDTH  (32),
        .WAIT_CYCLES (WC)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .MOV        (MOV),
        .ReadWrite  (ReadWrite),
        .DataType   (DataType),
        .SignedLoad (SignedLoad),
        .Address    (Address),
        .DataIn     (DataIn),
        .DataOut    (DataOut),
        .MOC        (MOC),
        .Error      (Error)
    );

    always #5 Clk = ~Clk;

    function automatic logic mdl_aligned(input logic [1:0] dt, input logic [7:0] a);
        if (dt == 2'd0) return 1'b1;
        if (dt == 2'd1) return (a % 2) == 0;
        return (a % 4) == 0;
    endfunction

    function automatic logic [31:0] mdl_read(input logic [1:0] dt, input logic sgn, input logic [7:0] a);
        logic [7:0]  b [4];
        logic [7:0]  ai;
        logic [15:0] h;
        for (int i = 0; i < 4; i++) begin
            ai   = a + 8'(i);
            b[i] = mdl[ai];
        end
        h = {b[0], b[1]};
        if (dt == 2'd0) return sgn ? {{24{b[0][7]}}, b[0]} : {24'd0, b[0]};
        if (dt == 2'd1) return sgn ? {{16{h[15]}}, h} : {16'd0, h};
        return {b[0], b[1], b[2], b[3]};
    endfunction

    task automatic mdl_write(input logic [1:0] dt, input logic [7:0] a, input logic [31:0] d);
        int nb;
        logic [7:0] ai;
        nb = (dt == 2'd0) ? 1 : (dt == 2'd1) ? 2 : 4;
        for (int i = 0; i < nb; i++) begin
            ai      = a + 8'(i);
            mdl[ai] = d[8*(nb-1-i) +: 8];
        end
    endtask

    task automatic wait_moc(output int n);
        n = 0;
        do begin
            @(negedge Clk);
            n++;
        end while (MOC !== 1'b1 && n < 64);
    endtask

    // One complete transfer; checks latency, Error, DataOut and single-cycle MOC.
    task automatic xfer(input logic rw, input logic [1:0] dt, input logic sgn, input logic [7:0] a,
                        input logic [31:0] d0, input logic [31:0] d1, input logic linger);
        logic al;
        int   beats;
        int   n;
        logic [7:0] ab;
        al    = mdl_aligned(dt, a);
        beats = (dt == 2'd3 && al) ? 2 : 1;
        @(negedge Clk);
        MOV = 1'b1; ReadWrite = rw; DataType = dt; SignedLoad = sgn; Address = a; DataIn = d0;
        for (int b = 0; b < beats; b++) begin
            n = 0;
            do begin
                @(negedge Clk);
                n++;
                if (b == 0 && n == 1) begin
                    Address = 8'($urandom); DataType = 2'($urandom);
                    ReadWrite = ~rw; SignedLoad = ~sgn;
                end
            end while (MOC !== 1'b1 && n < 64);
            n_cmp++;
            if (MOC !== 1'b1 || n != WC + 2) begin
                n_fail++;
                $display("FAIL latency a=%h dt=%0d beat=%0d: got %0d cycles moc=%b, want %0d", a, dt, b, n, MOC, WC + 2);
            end
            ab = a + 8'(4 * b);
            if (al) begin
                if (rw) mdl_dout = mdl_read(dt, sgn, ab);
                else mdl_write(dt, ab, (b == 0) ? d0 : d1);
            end
            n_cmp++;
            if (Error !== ~al) begin
                n_fail++;
                $display("FAIL error a=%h dt=%0d: got %b, want %b", a, dt, Error, ~al);
            end
            n_cmp++;
            if (DataOut !== mdl_dout) begin
                n_fail++;
                $display("FAIL dataout a=%h dt=%0d rw=%b: got %h, want %h", ab, dt, rw, DataOut, mdl_dout);
            end
            if (b == 0 && beats == 2) DataIn = d1;
        end
        if (linger) begin
            repeat (WC + 4) begin
                @(negedge Clk);
                n_cmp++;
                if (MOC !== 1'b0) begin
                    n_fail++;
                    $display("FAIL extra_moc a=%h dt=%0d: got %b, want 0", a, dt, MOC);
                end
            end
            MOV = 1'b0;
        end else begin
            MOV = 1'b0;
            @(negedge Clk);
            n_cmp++;
            if (MOC !== 1'b0) begin
                n_fail++;
                $display("FAIL moc_pulse a=%h: got %b, want 0", a, MOC);
            end
        end
        repeat (2) @(negedge Clk);
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        repeat (3) @(negedge Clk);
        n_cmp++;
        if (MOC !== 1'b0 || Error !== 1'b0 || DataOut !== 32'h0) begin
            n_fail++;
            $display("FAIL reset: got moc=%b err=%b dout=%h, want 0 0 00000000", MOC, Error, DataOut);
        end
        Reset = 1'b0;
        mdl_dout = 32'h0;
        @(negedge Clk);
    endtask

    task automatic test_preload();
        for (int i = 0; i < 64; i++) xfer(1'b0, 2'd2, 1'b0, 8'(4 * i), $urandom, 32'h0, 1'b0);
    endtask

    task automatic test_word_read();
        xfer(1'b0, 2'd2, 1'b0, 8'h00, 32'hFFD38197, 32'h0, 1'b0);
        n_cmp++;
        if ({dut.u_array.Mem[0], dut.u_array.Mem[1], dut.u_array.Mem[2], dut.u_array.Mem[3]} !== 32'hFFD38197) begin
            n_fail++;
            $display("FAIL preload_bytes: got %h %h %h %h, want FF D3 81 97", dut.u_array.Mem[0],
                     dut.u_array.Mem[1], dut.u_array.Mem[2], dut.u_array.Mem[3]);
        end
        xfer(1'b1, 2'd2, 1'b0, 8'h00, 32'h0, 32'h0, 1'b0);
        n_cmp++;
        if (DataOut !== 32'hFFD38197) begin
            n_fail++;
            $display("FAIL word_read: got %h, want FFD38197", DataOut);
        end
    endtask

    task automatic test_byte_half();
        xfer(1'b0, 2'd0, 1'b0, 8'h0C, 32'hFFD38197, 32'h0, 1'b0);
        n_cmp++;
        if (dut.u_array.Mem[8'h0C] !== 8'h97) begin
            n_fail++;
            $display("FAIL byte_write: got %h, want 97", dut.u_array.Mem[8'h0C]);
        end
        xfer(1'b1, 2'd0, 1'b1, 8'h0C, 32'h0, 32'h0, 1'b0);
        n_cmp++;
        if (DataOut !== 32'hFFFFFF97) begin
            n_fail++;
            $display("FAIL byte_signed: got %h, want FFFFFF97", DataOut);
        end
        xfer(1'b1, 2'd0, 1'b0, 8'h0C, 32'h0, 32'h0, 1'b0);
        n_cmp++;
        if (DataOut !== 32'h00000097) begin
            n_fail++;
            $display("FAIL byte_unsigned: got %h, want 00000097", DataOut);
        end
        xfer(1'b0, 2'd1, 1'b0, 8'h10, 32'h00008197, 32'h0, 1'b0);
        n_cmp++;
        if (dut.u_array.Mem[8'h10] !== 8'h81 || dut.u_array.Mem[8'h11] !== 8'h97) begin
            n_fail++;
            $display("FAIL half_write: got %h %h, want 81 97", dut.u_array.Mem[8'h10], dut.u_array.Mem[8'h11]);
        end
        xfer(1'b1, 2'd1, 1'b1, 8'h10, 32'h0, 32'h0, 1'b0);
        n_cmp++;
        if (DataOut !== 32'hFFFF8197) begin
            n_fail++;
            $display("FAIL half_signed: got %h, want FFFF8197", DataOut);
        end
    endtask

    task automatic test_dword_wrap();
        logic [31:0] hi, lo;
        xfer(1'b0, 2'd3, 1'b0, 8'hFC, 32'h00000001, 32'h00000003, 1'b1);
        hi = {dut.u_array.Mem[8'hFC], dut.u_array.Mem[8'hFD], dut.u_array.Mem[8'hFE], dut.u_array.Mem[8'hFF]};
        lo = {dut.u_array.Mem[8'h00], dut.u_array.Mem[8'h01], dut.u_array.Mem[8'h02], dut.u_array.Mem[8'h03]};
        n_cmp++;
        if (hi !== 32'h00000001 || lo !== 32'h00000003) begin
            n_fail++;
            $display("FAIL dword_wrap: got %h %h, want 00000001 00000003", hi, lo);
        end
        xfer(1'b1, 2'd3, 1'b0, 8'hFC, 32'h0, 32'h0, 1'b0);
        n_cmp++;
        if (DataOut !== 32'h00000003) begin
            n_fail++;
            $display("FAIL dword_read: got %h, want 00000003", DataOut);
        end
    endtask

    task automatic test_misaligned();
        logic [31:0] keep;
        keep = DataOut;
        xfer(1'b0, 2'd2, 1'b0, 8'h06, 32'hDEADBEEF, 32'h0, 1'b1);
        for (int i = 4; i < 10; i++) begin
            n_cmp++;
            if (dut.u_array.Mem[i] !== mdl[i]) begin
                n_fail++;
                $display("FAIL misaligned_mem[%0d]: got %h, want %h", i, dut.u_array.Mem[i], mdl[i]);
            end
        end
        n_cmp++;
        if (DataOut !== keep) begin
            n_fail++;
            $display("FAIL misaligned_dout: got %h, want %h", DataOut, keep);
        end
        xfer(1'b1, 2'd1, 1'b1, 8'h11, 32'h0, 32'h0, 1'b1);
        xfer(1'b1, 2'd3, 1'b0, 8'h02, 32'h0, 32'h0, 1'b1);
    endtask

    task automatic test_mov_drop();
        int n;
        @(negedge Clk);
        MOV = 1'b1; ReadWrite = 1'b1; DataType = 2'd3; SignedLoad = 1'b0; Address = 8'h30;
        @(negedge Clk);
        MOV = 1'b0;
        wait_moc(n);
        n_cmp++;
        if (MOC !== 1'b1 || n + 1 != WC + 2) begin
            n_fail++;
            $display("FAIL drop_latency: got %0d cycles moc=%b, want %0d", n + 1, MOC, WC + 2);
        end
        mdl_dout = mdl_read(2'd2, 1'b0, 8'h30);
        n_cmp++;
        if (DataOut !== mdl_dout || Error !== 1'b0) begin
            n_fail++;
            $display("FAIL drop_data: got %h err=%b, want %h err=0", DataOut, Error, mdl_dout);
        end
        repeat (WC + 4) begin
            @(negedge Clk);
            n_cmp++;
            if (MOC !== 1'b0 || Error !== 1'b0) begin
                n_fail++;
                $display("FAIL drop_beat2: got moc=%b err=%b, want 0 0", MOC, Error);
            end
        end
    endtask

    task automatic test_reset_mid();
        int n;
        @(negedge Clk);
        MOV = 1'b1; ReadWrite = 1'b0; DataType = 2'd3; SignedLoad = 1'b0; Address = 8'h20;
        DataIn = 32'hA1B2C3D4;
        wait_moc(n);
        n_cmp++;
        if (MOC !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_beat1: got moc=%b, want 1", MOC);
        end
        mdl_write(2'd2, 8'h20, 32'hA1B2C3D4);
        DataIn = 32'h55667788;
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        n_cmp++;
        if (MOC !== 1'b0 || DataOut !== 32'h0 || Error !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_outputs: got moc=%b dout=%h err=%b, want 0 00000000 0", MOC, DataOut, Error);
        end
        mdl_dout = 32'h0;
        Reset = 1'b0; MOV = 1'b0;
        repeat (WC + 4) begin
            @(negedge Clk);
            n_cmp++;
            if (MOC !== 1'b0) begin
                n_fail++;
                $display("FAIL rstmid_moc: got %b, want 0", MOC);
            end
        end
        for (int i = 8'h20; i < 8'h28; i++) begin
            n_cmp++;
            if (dut.u_array.Mem[i] !== mdl[i]) begin
                n_fail++;
                $display("FAIL rstmid_mem[%0h]: got %h, want %h", i, dut.u_array.Mem[i], mdl[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [1:0] dt;
        logic [7:0] a;
        for (int t = 0; t < 60; t++) begin
            dt = 2'($urandom);
            a  = 8'($urandom);
            if ($urandom_range(0, 3) != 0) begin
                if (dt == 2'd1) a[0] = 1'b0;
                else if (dt[1]) a[1:0] = 2'b00;
            end
            xfer(1'($urandom), dt, 1'($urandom), a, $urandom, $urandom, 1'($urandom));
        end
    endtask

    task automatic test_mem_image();
        for (int i = 0; i < 256; i++) begin
            n_cmp++;
            if (dut.u_array.Mem[i] !== mdl[i]) begin
                n_fail++;
                $display("FAIL mem_image[%0h]: got %h, want %h", i, dut.u_array.Mem[i], mdl[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_preload();
        test_word_read();
        test_byte_half();
        test_dword_wrap();
        test_misaligned();
        test_mov_drop();
        test_reset_mid();
        test_random();
        test_mem_image();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
